symbol_sequence_gen: RTL and testbench

- Transmit-side counterpart to the team's 7-bit symbol recognizer FSM.
- On a start command, plays one of four fixed symbol programs as 7-bit codes with a valid strobe. Supports optional idle gaps and a valid/ready stall.
- Drives the recognizer's 7-bit symbol bus and its valid bit. Reports the terminal recognizer state the program is meant to produce.

---
 rtl/symbol_sequence_gen.sv | 161 ++++++++++++++++
 tb/tb_symbol_sequence_gen.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/symbol_sequence_gen.sv
// Symbol sequence generator: plays one of four fixed 7-bit symbol programs
// toward the symbol recognizer, with optional idle gaps and valid/ready stalls.
module symbol_sequence_gen #(
    parameter int GAP  = 2,
    parameter int GAPW = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       sym_ready,
    output logic [6:0] sym,
    output logic       sym_valid,
    output logic       busy,
    output logic       done,
    output logic [2:0] seq_idx,
    output logic [3:0] expect_state
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam logic [6:0] S1 = 7'b1011000;
    localparam logic [6:0] S2 = 7'b1101011;
    localparam logic [6:0] S3 = 7'b1001111;
    localparam logic [6:0] S4 = 7'b0101000;
    localparam logic [6:0] S5 = 7'b0001100;
    localparam logic [6:0] T6 = 7'b0110010;
    localparam logic [6:0] T7 = 7'b0010110;
    localparam logic [6:0] T8 = 7'b0100011;

    // Counter reload value for a gap; only meaningful when GAP > 0.
    localparam logic [GAPW-1:0] GAP_LOAD = (GAP > 0) ? GAPW'(GAP - 1) : '0;

    state_t          r_state;
    state_t          w_next_state;
    logic [1:0]      r_mode;
    logic [1:0]      w_next_mode;
    logic [2:0]      r_idx;
    logic [2:0]      w_next_idx;
    logic [GAPW-1:0] r_gap;
    logic [GAPW-1:0] w_next_gap;
    logic [3:0]      r_expect;
    logic [3:0]      w_next_expect;

    logic [6:0]      w_code;
    logic [2:0]      w_len;
    logic [3:0]      w_prog_expect;
    logic            w_last;

    // Program ROM indexed by latched mode and position within the program.
    always_comb begin
        w_code = 7'b0;
        case ({r_mode, r_idx})
            5'b00_000: w_code = S1;
            5'b00_001: w_code = S2;
            5'b00_010: w_code = S3;
            5'b00_011: w_code = T6;
            5'b01_000: w_code = S3;
            5'b01_001: w_code = S4;
            5'b01_010: w_code = S5;
            5'b01_011: w_code = T8;
            5'b10_000: w_code = S1;
            5'b10_001: w_code = T7;
            5'b11_000: w_code = S1;
            5'b11_001: w_code = S2;
            5'b11_010: w_code = S3;
            5'b11_011: w_code = S4;
            5'b11_100: w_code = S5;
            5'b11_101: w_code = T8;
            default:   w_code = 7'b0;
        endcase
    end

    always_comb begin
        w_len         = 3'd4;
        w_prog_expect = 4'b1001;
        case (r_mode)
            2'd0: begin w_len = 3'd4; w_prog_expect = 4'b1001; end
            2'd1: begin w_len = 3'd4; w_prog_expect = 4'b1010; end
            2'd2: begin w_len = 3'd2; w_prog_expect = 4'b1000; end
            2'd3: begin w_len = 3'd6; w_prog_expect = 4'b1010; end
            default: begin w_len = 3'd4; w_prog_expect = 4'b1001; end
        endcase
    end

    assign w_last = (r_idx == (w_len - 3'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_mode   <= 2'd0;
            r_idx    <= 3'd0;
            r_gap    <= '0;
            r_expect <= 4'd0;
        end else begin
            r_state  <= w_next_state;
            r_mode   <= w_next_mode;
            r_idx    <= w_next_idx;
            r_gap    <= w_next_gap;
            r_expect <= w_next_expect;
        end
    end

    // A stalled SEND (sym_ready low) holds every register, freezing index and gap count.
    always_comb begin
        w_next_state  = r_state;
        w_next_mode   = r_mode;
        w_next_idx    = r_idx;
        w_next_gap    = r_gap;
        w_next_expect = r_expect;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_mode  = mode;
                    w_next_idx   = 3'd0;
                    w_next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                if (sym_ready) begin
                    if (w_last) begin
                        w_next_state  = ST_DONE;
                        w_next_expect = w_prog_expect;
                    end else if (GAP == 0) begin
                        w_next_idx = r_idx + 3'd1;
                    end else begin
                        w_next_state = ST_GAP;
                        w_next_gap   = GAP_LOAD;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap == '0) begin
                    w_next_state = ST_SEND;
                    w_next_idx   = r_idx + 3'd1;
                end else begin
                    w_next_gap = r_gap - GAPW'(1);
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign sym_valid    = (r_state == ST_SEND);
    assign sym          = sym_valid ? w_code : 7'b0;
    assign busy         = (r_state == ST_SEND) || (r_state == ST_GAP);
    assign done         = (r_state == ST_DONE);
    assign seq_idx      = r_idx;
    assign expect_state = r_expect;

endmodule

// File: tb/tb_symbol_sequence_gen.sv
// Scoreboard bench for symbol_sequence_gen: one instance with GAP=2, one with GAP=0.
module tb_symbol_sequence_gen;

    localparam logic [6:0] S1 = 7'b1011000;
    localparam logic [6:0] S2 = 7'b1101011;
    localparam logic [6:0] S3 = 7'b1001111;
    localparam logic [6:0] S4 = 7'b0101000;
    localparam logic [6:0] S5 = 7'b0001100;
    localparam logic [6:0] T6 = 7'b0110010;
    localparam logic [6:0] T7 = 7'b0010110;
    localparam logic [6:0] T8 = 7'b0100011;

    typedef struct {
        bit         isDone;
        logic [6:0] sym;
        logic [2:0] idx;
        logic [3:0] expState;
        int         cyc;
    } item_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic       rstA = 1'b1, startA = 1'b0, readyA = 1'b1;
    logic [1:0] modeA = 2'd0;
    logic [6:0] symA;
    logic       validA, busyA, doneA;
    logic [2:0] idxA;
    logic [3:0] expA;

    logic       rstB = 1'b1, startB = 1'b0, readyB = 1'b1;
    logic [1:0] modeB = 2'd0;
    logic [6:0] symB;
    logic       validB, busyB, doneB;
    logic [2:0] idxB;
    logic [3:0] expB;

    item_t qA[$];
    item_t qB[$];

    symbol_sequence_gen #(.GAP(2), .GAPW(4)) dutA (
        .clk(clk), .reset(rstA), .start(startA), .mode(modeA), .sym_ready(readyA),
        .sym(symA), .sym_valid(validA), .busy(busyA), .done(doneA),
        .seq_idx(idxA), .expect_state(expA)
    );

    symbol_sequence_gen #(.GAP(0), .GAPW(4)) dutB (
        .clk(clk), .reset(rstB), .start(startB), .mode(modeB), .sym_ready(readyB),
        .sym(symB), .sym_valid(validB), .busy(busyB), .done(doneB),
        .seq_idx(idxB), .expect_state(expB)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic waitCycle(input int target);
        while (cyc < target) tick();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic pushSym(input bit toB, input logic [6:0] s, input logic [2:0] idx, input int c);
        item_t it;
        it.isDone = 1'b0; it.sym = s; it.idx = idx; it.expState = 4'd0; it.cyc = c;
        if (toB) qB.push_back(it); else qA.push_back(it);
    endtask

    task automatic pushDone(input bit toB, input logic [3:0] e, input int c);
        item_t it;
        it.isDone = 1'b1; it.sym = 7'd0; it.idx = 3'd0; it.expState = e; it.cyc = c;
        if (toB) qB.push_back(it); else qA.push_back(it);
    endtask

    // Drives a one-cycle start pulse in the current cycle.
    task automatic applyStimulus(input bit toB, input logic [1:0] m);
        if (toB) begin startB = 1'b1; modeB = m; end
        else     begin startA = 1'b1; modeA = m; end
        tick();
        startA = 1'b0;
        startB = 1'b0;
    endtask

    task automatic compareItem(input string who, input item_t e, input bit gotDone,
                               input logic [6:0] s, input logic [2:0] idx, input logic [3:0] es);
        checks++;
        if (e.isDone != gotDone || e.cyc != cyc ||
            (!gotDone && (s !== e.sym || idx !== e.idx)) ||
            (gotDone && es !== e.expState)) begin
            failures++;
            $display("[TB] FAIL %s: got done=%0b sym=%b idx=%0d exp=%b cyc=%0d expected done=%0b sym=%b idx=%0d exp=%b cyc=%0d",
                     who, gotDone, s, idx, es, cyc, e.isDone, e.sym, e.idx, e.expState, e.cyc);
        end
    endtask

    task automatic checkZero(input string who, input logic [6:0] s, input logic v);
        if (!v) begin
            checks++;
            if (s !== 7'd0) begin
                failures++;
                $display("[TB] FAIL %s idle sym: got %b expected 0000000 (cycle %0d)", who, s, cyc);
            end
        end
    endtask

    // Monitors: pop an expected item on every transfer or done pulse.
    always @(negedge clk) begin
        checkZero("A", symA, validA);
        if ((validA && readyA) || doneA) begin
            if (qA.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL A unexpected output: sym=%b done=%0b expected none (cycle %0d)", symA, doneA, cyc);
            end else begin
                compareItem("A", qA.pop_front(), doneA, symA, idxA, expA);
            end
        end
    end

    always @(negedge clk) begin
        checkZero("B", symB, validB);
        if ((validB && readyB) || doneB) begin
            if (qB.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL B unexpected output: sym=%b done=%0b expected none (cycle %0d)", symB, doneB, cyc);
            end else begin
                compareItem("B", qB.pop_front(), doneB, symB, idxB, expB);
            end
        end
    end

    initial begin
        int base;
        int base2;
        int waitCnt;

        repeat (3) tick();
        checkOutput("A reset sym", 32'(symA), 32'd0);
        checkOutput("A reset valid", 32'(validA), 32'd0);
        checkOutput("A reset busy", 32'(busyA), 32'd0);
        checkOutput("A reset done", 32'(doneA), 32'd0);
        checkOutput("A reset idx", 32'(idxA), 32'd0);
        checkOutput("A reset expect", 32'(expA), 32'd0);
        checkOutput("B reset valid", 32'(validB), 32'd0);
        checkOutput("B reset busy", 32'(busyB), 32'd0);
        checkOutput("B reset expect", 32'(expB), 32'd0);
        rstA = 1'b0;
        rstB = 1'b0;
        tick();

        // Mode 0 with GAP=2: symbols every third cycle, done at +11.
        base = cyc;
        pushSym(0, S1, 3'd0, base + 1);
        pushSym(0, S2, 3'd1, base + 4);
        pushSym(0, S3, 3'd2, base + 7);
        pushSym(0, T6, 3'd3, base + 10);
        pushDone(0, 4'b1001, base + 11);
        applyStimulus(0, 2'd0);
        waitCycle(base + 8);
        checkOutput("A busy mid-program", 32'(busyA), 32'd1);
        waitCycle(base + 12);
        checkOutput("A expect held in idle", 32'(expA), 32'b1001);
        checkOutput("A busy after done", 32'(busyA), 32'd0);
        tick();

        // Starts while busy and in the DONE cycle are ignored; next-cycle start runs mode 2.
        base = cyc;
        pushSym(0, S1, 3'd0, base + 1);
        pushSym(0, S2, 3'd1, base + 4);
        pushSym(0, S3, 3'd2, base + 7);
        pushSym(0, T6, 3'd3, base + 10);
        pushDone(0, 4'b1001, base + 11);
        pushSym(0, S1, 3'd0, base + 13);
        pushSym(0, T7, 3'd1, base + 16);
        pushDone(0, 4'b1000, base + 17);
        applyStimulus(0, 2'd0);
        waitCycle(base + 5);
        applyStimulus(0, 2'd1);
        waitCycle(base + 11);
        startA = 1'b1;
        modeA = 2'd1;
        tick();
        modeA = 2'd2;
        tick();
        startA = 1'b0;
        waitCycle(base + 19);

        // Mode 1 with a 3-cycle stall on the second symbol.
        base = cyc;
        pushSym(0, S3, 3'd0, base + 1);
        pushSym(0, S4, 3'd1, base + 7);
        pushSym(0, S5, 3'd2, base + 10);
        pushSym(0, T8, 3'd3, base + 13);
        pushDone(0, 4'b1010, base + 14);
        applyStimulus(0, 2'd1);
        waitCycle(base + 4);
        readyA = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("A stall sym", 32'(symA), 32'(S4));
            checkOutput("A stall valid", 32'(validA), 32'd1);
            checkOutput("A stall idx", 32'(idxA), 32'd1);
            tick();
        end
        readyA = 1'b1;
        waitCycle(base + 16);

        // Reset during the gap after the second symbol of mode 0.
        base = cyc;
        pushSym(0, S1, 3'd0, base + 1);
        pushSym(0, S2, 3'd1, base + 4);
        applyStimulus(0, 2'd0);
        waitCycle(base + 5);
        rstA = 1'b1;
        tick();
        rstA = 1'b0;
        checkOutput("A abort sym", 32'(symA), 32'd0);
        checkOutput("A abort valid", 32'(validA), 32'd0);
        checkOutput("A abort busy", 32'(busyA), 32'd0);
        checkOutput("A abort done", 32'(doneA), 32'd0);
        checkOutput("A abort idx", 32'(idxA), 32'd0);
        checkOutput("A abort expect", 32'(expA), 32'd0);
        tick();
        base2 = cyc;
        pushSym(0, S3, 3'd0, base2 + 1);
        pushSym(0, S4, 3'd1, base2 + 4);
        pushSym(0, S5, 3'd2, base2 + 7);
        pushSym(0, T8, 3'd3, base2 + 10);
        pushDone(0, 4'b1010, base2 + 11);
        applyStimulus(0, 2'd1);
        waitCycle(base2 + 13);

        // Mode 3 with GAP=0: six back-to-back symbols, done right after.
        base = cyc;
        pushSym(1, S1, 3'd0, base + 1);
        pushSym(1, S2, 3'd1, base + 2);
        pushSym(1, S3, 3'd2, base + 3);
        pushSym(1, S4, 3'd3, base + 4);
        pushSym(1, S5, 3'd4, base + 5);
        pushSym(1, T8, 3'd5, base + 6);
        pushDone(1, 4'b1010, base + 7);
        applyStimulus(1, 2'd3);
        waitCycle(base + 9);
        checkOutput("B expect held in idle", 32'(expB), 32'b1010);

        waitCnt = 0;
        while ((qA.size() != 0 || qB.size() != 0) && waitCnt < 100) begin
            tick();
            waitCnt++;
        end
        checkOutput("A scoreboard drained", 32'(qA.size()), 32'd0);
        checkOutput("B scoreboard drained", 32'(qB.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
